lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port_pkg.sv | 25 ++
 rtl/lsu_align_chk.sv | 31 +++
 rtl/lsu_mem_port.sv | 120 ++++++++++++
 tb/tb_lsu_mem_port.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// rtl/lsu_mem_port_pkg.sv - shared load/store size codes and LSU FSM state encodings
package lsu_mem_port_pkg;

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  function automatic logic size_is_half(input logic [2:0] size);
    return (size == FUNCT3_LS_H) || (size == FUNCT3_LS_HU);
  endfunction

  function automatic logic size_is_byte(input logic [2:0] size);
    return (size == FUNCT3_LS_B) || (size == FUNCT3_LS_BU);
  endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// rtl/lsu_align_chk.sv - combinational misalignment, range and size-code check
module lsu_align_chk #(
  parameter int DEPTH = 1024
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  output logic        err
);
  import lsu_mem_port_pkg::*;

  // Compare in 34 bits so DEPTH*4 cannot overflow the 32-bit address space.
  localparam logic [33:0] LIMIT = 34'(DEPTH) << 2;

  logic align_err;
  logic range_err;

  always_comb begin
    align_err = 1'b0;
    if (size_is_half(size)) begin
      align_err = addr[0];
    end else if (size == FUNCT3_LS_W) begin
      align_err = (addr[1:0] != 2'b00);
    end else if (!size_is_byte(size)) begin
      align_err = 1'b1;
    end
  end

  assign range_err = ({2'b00, addr} >= LIMIT);
  assign err       = align_err | range_err;

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - single-outstanding load/store port between core and word RAM
module lsu_mem_port #(
  parameter int DEPTH    = 1024,
  parameter int LD_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_size,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wd,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rd,
  output logic                rsp_err,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [2:0]          mem_size,
  output logic [31:0]         mem_wd,
  input  logic [31:0]         mem_rd,
  output logic [LD_CNT_W-1:0] ld_cnt,
  output logic [LD_CNT_W-1:0] st_cnt
);
  import lsu_mem_port_pkg::*;

  lsu_state_e state;
  lsu_state_e state_next;

  logic accept;
  logic chk_err;
  logic we_q;

  lsu_align_chk #(
    .DEPTH(DEPTH)
  ) u_align_chk (
    .addr(req_addr),
    .size(req_size),
    .err (chk_err)
  );

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) begin
          state_next = chk_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_we     = we_q;
        state_next = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // mem_* double as the request registers for good requests, so an errored
  // request leaves the memory-side bus at its last legal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      rsp_rd   <= 32'd0;
      rsp_err  <= 1'b0;
      mem_addr <= 32'd0;
      mem_size <= FUNCT3_LS_W;
      mem_wd   <= 32'd0;
      ld_cnt   <= '0;
      st_cnt   <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        rsp_err <= chk_err;
        rsp_rd  <= 32'd0;
        if (!chk_err) begin
          mem_addr <= req_addr;
          mem_size <= req_size;
          mem_wd   <= req_wd;
        end
      end
      if (state == CAPTURE) begin
        rsp_rd <= mem_rd;
      end
      if ((state == RESP) && rsp_ready && !rsp_err) begin
        if (we_q) begin
          st_cnt <= st_cnt + LD_CNT_W'(1);
        end else begin
          ld_cnt <= ld_cnt + LD_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - directed vector bench for lsu_mem_port with a one-cycle RAM responder
module tb_lsu_mem_port;

  localparam int DEPTH    = 256;
  localparam int LD_CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_size;
  logic [31:0]         req_addr;
  logic [31:0]         req_wd;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_rd;
  logic                rsp_err;
  logic                mem_we;
  logic [31:0]         mem_addr;
  logic [2:0]          mem_size;
  logic [31:0]         mem_wd;
  logic [31:0]         mem_rd;
  logic [LD_CNT_W-1:0] ld_cnt;
  logic [LD_CNT_W-1:0] st_cnt;

  lsu_mem_port #(
    .DEPTH   (DEPTH),
    .LD_CNT_W(LD_CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_size (req_size),
    .req_addr (req_addr),
    .req_wd   (req_wd),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rd   (rsp_rd),
    .rsp_err  (rsp_err),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_size (mem_size),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .ld_cnt   (ld_cnt),
    .st_cnt   (st_cnt)
  );

  always #5 clk = ~clk;

  // RAM responder: byte-lane writes, read data formatted from the current size, one-cycle latency.
  logic [31:0] ram [0:DEPTH-1];

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] sz);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[int'(off)*8 +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_size[1:0])
        2'b00:   ram[mem_addr[9:2]][int'(mem_addr[1:0])*8 +: 8] <= mem_wd[7:0];
        2'b01:   ram[mem_addr[9:2]][int'(mem_addr[1])*16 +: 16] <= mem_wd[15:0];
        default: ram[mem_addr[9:2]] <= mem_wd;
      endcase
    end
    mem_rd <= fmt(ram[mem_addr[9:2]], mem_addr[1:0], mem_size);
  end

  int we_cycles = 0;
  always @(negedge clk) begin
    if (mem_we) we_cycles++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  // Caller is #1 after a rising edge with the DUT idle; returns the same way after the handshake.
  task automatic run_req(input string name, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int hold);
    int lat;
    int we0;
    we0 = we_cycles;
    check({name, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wd    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      if (!we && !exp_err) begin
        check({name, " mem_size held"}, 32'(mem_size), 32'(size));
        check({name, " mem_addr held"}, mem_addr, addr);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " rsp_rd"}, rsp_rd, exp_rd);
    check({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      check({name, " bp rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, " bp rsp_rd"}, rsp_rd, exp_rd);
      check({name, " bp req_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    check({name, " mem_we cycles"}, 32'(we_cycles - we0), (we && !exp_err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'd0;
    mem_rd    = 32'd0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'd0;
    req_wd    = 32'd0;
    rsp_ready = 1'b0;

    //                 we    size    addr          wd             exp_rd         err   lat
    vecs[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,         1'b0, 2};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0, 3};
    vecs[2]  = '{1'b1, 3'b000, 32'h13,  32'h80,       32'h0,         1'b0, 2};
    vecs[3]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80,  1'b0, 3};
    vecs[4]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080,  1'b0, 3};
    vecs[5]  = '{1'b0, 3'b010, 32'h12,  32'h0,        32'h0,         1'b1, 1};
    vecs[6]  = '{1'b1, 3'b001, 32'h400, 32'h1234,     32'h0,         1'b1, 1};
    vecs[7]  = '{1'b0, 3'b001, 32'h11,  32'h0,        32'h0,         1'b1, 1};
    vecs[8]  = '{1'b1, 3'b001, 32'h20,  32'h1234ABCD, 32'h0,         1'b0, 2};
    vecs[9]  = '{1'b0, 3'b101, 32'h20,  32'h0,        32'h0000ABCD,  1'b0, 3};
    vecs[10] = '{1'b0, 3'b001, 32'h20,  32'h0,        32'hFFFFABCD,  1'b0, 3};
    vecs[11] = '{1'b0, 3'b011, 32'h20,  32'h0,        32'h0,         1'b1, 1};
    vecs[12] = '{1'b1, 3'b010, 32'h3FC, 32'h0BADF00D, 32'h0,         1'b0, 2};
    vecs[13] = '{1'b0, 3'b010, 32'h3FC, 32'h0,        32'h0BADF00D,  1'b0, 3};
    vecs[14] = '{1'b0, 3'b000, 32'h3FF, 32'h0,        32'h0000000B,  1'b0, 3};
    vecs[15] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF,  1'b0, 3};

    repeat (3) @(posedge clk);
    #1;
    check("req_ready in reset", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rd", rsp_rd, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_size", 32'(mem_size), 32'd2);
    check("reset mem_wd", mem_wd, 32'd0);
    check("reset ld_cnt", 32'(ld_cnt), 32'd0);
    check("reset st_cnt", 32'(st_cnt), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd,
              vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, 0);
    end
    check("table ld_cnt", 32'(ld_cnt), 32'd8);
    check("table st_cnt", 32'(st_cnt), 32'd4);

    run_req("bp sh", 1'b1, 3'b001, 32'h12, 32'h0000FFFF, 32'h0, 1'b0, 2, 0);
    run_req("bp lh", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 5);
    check("bp ld_cnt", 32'(ld_cnt), 32'd9);
    check("bp st_cnt", 32'(st_cnt), 32'd5);

    // Reset while the load sits in CAPTURE.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd0);
    check("midrst ld_cnt", 32'(ld_cnt), 32'd0);
    check("midrst st_cnt", 32'(st_cnt), 32'd0);
    check("midrst mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midrst no rsp", 32'(rsp_valid), 32'd0);
    end
    run_req("post rst lw", 1'b0, 3'b010, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 0);
    check("post rst ld_cnt", 32'(ld_cnt), 32'd1);
    check("post rst st_cnt", 32'(st_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
